// File: rtl/weight_mem_pkg.sv
// ============================================================================
// Module   : weight_mem_pkg
// Brief    : Shared types and defaults for the weight-memory read responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package weight_mem_pkg;

    localparam int ARBURST_W  = 4;
    localparam int DEF_DEPTH  = 1024;
    localparam int DEF_BURST  = 16;
    localparam int DEF_RD_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LAT   = 2'd1,
        ST_BURST = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/wmem_array.sv
// ============================================================================
// Module   : wmem_array
// Brief    : DW x DEPTH word store, one write port, registered read port
//            with read-before-write on address collision.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wmem_array
    import weight_mem_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [DW-1:0]            i_wr_data,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    input  logic                     i_rd_zero,
    output logic [DW-1:0]            o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    // Storage is deliberately left out of reset so preloaded weights survive.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= i_rd_zero ? '0 : r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/weight_mem_responder.sv
// ============================================================================
// Module   : weight_mem_responder
// Brief    : AR/R burst read responder over a preloadable weight store.
//            Optional macro WMEM_OOB_CHECK_EN adds err_oob and zeroes beats
//            that fall past the end of memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_mem_responder
    import weight_mem_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int BURST  = DEF_BURST,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AW-1:0]            araddr,
    input  logic                     arvalid,
    input  logic [ARBURST_W-1:0]     arburst,
    output logic                     arready,
    output logic [DW-1:0]            rdata,
    output logic                     rvalid,
    output logic                     rlast,
`ifdef WMEM_OOB_CHECK_EN
    output logic                     err_oob,
`endif
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DW-1:0]            wr_data
);

    localparam int                   IW       = $clog2(DEPTH);
    localparam logic [ARBURST_W-1:0] LEN_MAX  = ARBURST_W'(BURST - 1);
    localparam logic [ARBURST_W-1:0] LAT_LAST = ARBURST_W'(RD_LAT);

    state_t               r_state, w_state_nxt;
    logic                 r_arready, w_arready_nxt;
    logic                 r_rvalid, w_rvalid_nxt;
    logic                 r_rlast, w_rlast_nxt;
    logic [IW-1:0]        r_base;
    logic [ARBURST_W-1:0] r_len_m1;
    logic [ARBURST_W-1:0] r_idx;
    logic [ARBURST_W-1:0] r_lat_cnt;

    logic                 w_hs;
    logic [ARBURST_W-1:0] w_arb_clamp;
    logic                 w_issue;
    logic [ARBURST_W-1:0] w_beat_idx;
    logic [IW-1:0]        w_beat_base;
    logic [ARBURST_W-1:0] w_beat_len_m1;
    logic [IW-1:0]        w_rd_addr;
    logic                 w_rd_zero;

    // arready is only ever high in IDLE, so this is the IDLE handshake.
    assign w_hs        = arvalid & r_arready;
    assign w_arb_clamp = ({1'b0, arburst} >= (ARBURST_W + 1)'(BURST)) ? LEN_MAX : arburst;

    // With RD_LAT=0 the first beat issues on the handshake edge itself, so the
    // base and length must come straight from the request in IDLE.
    assign w_beat_base   = (r_state == ST_IDLE) ? araddr[IW-1:0] : r_base;
    assign w_beat_len_m1 = (r_state == ST_IDLE) ? w_arb_clamp : r_len_m1;
    assign w_rd_addr     = w_beat_base + IW'(w_beat_idx);

    always_comb begin
        w_state_nxt   = r_state;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rlast_nxt   = r_rlast;
        w_issue       = 1'b0;
        w_beat_idx    = r_idx;
        case (r_state)
            ST_IDLE: begin
                w_arready_nxt = 1'b1;
                if (w_hs) begin
                    w_arready_nxt = 1'b0;
                    w_beat_idx    = '0;
                    if (RD_LAT == 0) begin
                        w_issue     = 1'b1;
                        w_state_nxt = ST_BURST;
                    end else begin
                        w_state_nxt = ST_LAT;
                    end
                end
            end
            ST_LAT: begin
                if (r_lat_cnt == LAT_LAST) begin
                    w_issue     = 1'b1;
                    w_beat_idx  = '0;
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (r_rlast) begin
                    w_rvalid_nxt  = 1'b0;
                    w_rlast_nxt   = 1'b0;
                    w_arready_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_issue = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_issue) begin
            w_rvalid_nxt = 1'b1;
            w_rlast_nxt  = (w_beat_idx == w_beat_len_m1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_base    <= '0;
            r_len_m1  <= '0;
            r_idx     <= '0;
            r_lat_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rlast   <= w_rlast_nxt;
            if (w_hs) begin
                r_base    <= araddr[IW-1:0];
                r_len_m1  <= w_arb_clamp;
                r_lat_cnt <= ARBURST_W'(1);
            end else if (r_state == ST_LAT) begin
                r_lat_cnt <= r_lat_cnt + ARBURST_W'(1);
            end
            if (w_issue) begin
                r_idx <= w_beat_idx + ARBURST_W'(1);
            end
        end
    end

`ifdef WMEM_OOB_CHECK_EN
    logic          r_err_oob;
    logic [IW:0]   w_end_addr;
    logic [IW:0]   w_beat_addr_full;
    logic          w_upper_nz;

    assign w_upper_nz       = |(araddr >> IW);
    assign w_end_addr       = {1'b0, araddr[IW-1:0]} + (IW + 1)'(w_arb_clamp);
    assign w_beat_addr_full = {1'b0, w_beat_base} + (IW + 1)'(w_beat_idx);
    assign w_rd_zero        = w_beat_addr_full[IW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_oob <= 1'b0;
        end else if (w_hs && (w_upper_nz || w_end_addr[IW])) begin
            r_err_oob <= 1'b1;
        end
    end

    assign err_oob = r_err_oob;
`else
    logic w_unused_upper;
    assign w_unused_upper = ^(araddr >> IW);
    assign w_rd_zero      = 1'b0;
`endif

    wmem_array #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_issue),
        .i_rd_addr (w_rd_addr),
        .i_rd_zero (w_rd_zero),
        .o_rd_data (rdata)
    );

    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rlast   = r_rlast;

endmodule

`default_nettype wire

// File: tb/tb_weight_mem_responder.sv
// ============================================================================
// Module   : tb_weight_mem_responder
// Brief    : Scoreboard bench for weight_mem_responder (RD_LAT=1 main DUT,
//            RD_LAT=0 side instance for the zero-latency single beat case).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_weight_mem_responder;

    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int DEPTH  = 1024;
    localparam int IW     = 10;
    localparam int RD_LAT = 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } beat_t;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic [AW-1:0] araddr  = '0;
    logic          arvalid = 1'b0;
    logic          av0     = 1'b0;
    logic [3:0]    arburst = '0;
    logic          wr_en   = 1'b0;
    logic [IW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;

    logic          arready, rvalid, rlast;
    logic [DW-1:0] rdata;
    logic          arready0, rvalid0, rlast0;
    logic [DW-1:0] rdata0;
`ifdef WMEM_OOB_CHECK_EN
    logic          err_oob, err_oob0;
`endif

    int            n_chk  = 0;
    int            n_fail = 0;
    int            cyc    = 0;
    int            hs_cnt = 0;
    int            hs_k   = 0;
    logic [DW-1:0] mdl [DEPTH];
    beat_t         sb [$];
    beat_t         b;
    logic          post_last = 1'b0;
    logic [DW-1:0] last_data = '0;
    logic [DW-1:0] d;
    int            a;

    always #5 clk = ~clk;

    weight_mem_responder #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .BURST(16), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .araddr(araddr), .arvalid(arvalid), .arburst(arburst),
        .arready(arready), .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
`ifdef WMEM_OOB_CHECK_EN
        .err_oob(err_oob),
`endif
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    weight_mem_responder #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .BURST(16), .RD_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .araddr(araddr), .arvalid(av0), .arburst(arburst),
        .arready(arready0), .rdata(rdata0), .rvalid(rvalid0), .rlast(rlast0),
`ifdef WMEM_OOB_CHECK_EN
        .err_oob(err_oob0),
`endif
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, pushes expectations at handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            post_last = 1'b0;
        end else begin
            if (post_last) begin
                chk("arready_after_last", 64'(arready), 64'd1);
                chk("rvalid_gap", 64'(rvalid), 64'd0);
                chk("rdata_hold", 64'(rdata), 64'(last_data));
                post_last = 1'b0;
            end
            if (rvalid) begin
                chk("arready_rvalid_excl", 64'(arready), 64'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(rvalid), 64'd0);
                end else begin
                    b = sb.pop_front();
                    chk("beat_data", 64'(rdata), 64'(b.data));
                    chk("beat_last", 64'(rlast), 64'(b.last));
                    chk("beat_cycle", 64'(cyc), 64'(b.cyc));
                    if (b.last) begin
                        post_last = 1'b1;
                        last_data = b.data;
                    end
                end
            end
            if (arvalid && arready) begin
                hs_k = cyc + 1;
                hs_cnt++;
                for (int i = 0; i <= int'(arburst); i++) begin
                    a = int'(araddr[IW-1:0]) + i;
                    d = mdl[a % DEPTH];
`ifdef WMEM_OOB_CHECK_EN
                    if (a >= DEPTH) d = '0;
`endif
                    sb.push_back('{data: d, last: (i == int'(arburst)), cyc: hs_k + RD_LAT + i});
                end
            end
        end
    end

    task automatic wr_word(input int addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_addr = IW'(addr);
        wr_data = data;
        mdl[addr] = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (hs_cnt >= n) return;
        end
        chk("handshake_timeout", 64'(hs_cnt), 64'(n));
    endtask

    task automatic wait_cyc(input int c);
        for (int n = 0; n < 200; n++) begin
            if (cyc >= c) return;
            @(posedge clk); #1;
        end
        chk("cycle_timeout", 64'(cyc), 64'(c));
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && arready && !post_last) return;
        end
        chk("idle_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic burst(input int addr, input int blen_m1);
        araddr  = AW'(addr);
        arburst = 4'(blen_m1);
        arvalid = 1'b1;
        wait_hs(hs_cnt + 1);
        arvalid = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
`ifdef WMEM_OOB_CHECK_EN
        chk("rst_err_oob", 64'(err_oob), 64'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arready_after_rst", 64'(arready), 64'd1);

        for (int i = 0; i < 32; i++) wr_word(i, DW'(32'h100 + i));

        // Nine-beat burst from address 0.
        burst(0, 8);

        // Back-to-back requests with arvalid held high.
        araddr  = '0;
        arburst = 4'd8;
        arvalid = 1'b1;
        wait_hs(hs_cnt + 1);
        araddr = AW'(9);
        wait_hs(hs_cnt + 1);
        arvalid = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of beat 3.
        araddr  = '0;
        arburst = 4'd8;
        arvalid = 1'b1;
        wait_hs(hs_cnt + 1);
        arvalid = 1'b0;
        wait_cyc(hs_k + RD_LAT + 3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rvalid", 64'(rvalid), 64'd0);
        chk("async_rst_rlast", 64'(rlast), 64'd0);
        chk("async_rst_rdata", 64'(rdata), 64'd0);
        chk("async_rst_arready", 64'(arready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("arready_low_at_release", 64'(arready), 64'd0);
        @(posedge clk); #1;
        chk("arready_rise_after_release", 64'(arready), 64'd1);
        burst(0, 8);

        // Write to base+2 on the same edge beat 2 is read.
        araddr  = '0;
        arburst = 4'd8;
        arvalid = 1'b1;
        wait_hs(hs_cnt + 1);
        arvalid = 1'b0;
        wait_cyc(hs_k + RD_LAT + 1);
        wr_word(2, 32'hDEAD_0002);
        wait_idle();
        burst(2, 0);

        // Wrap past the end of memory.
        wr_word(1020, 32'hAAAA_0000);
        wr_word(1021, 32'hBBBB_0000);
        wr_word(1022, 32'hCCCC_0000);
        wr_word(1023, 32'hDDDD_0000);
        wr_word(0, 32'hEEEE_0000);
        wr_word(1, 32'hFFFF_0000);
        wr_word(2, 32'h1111_0000);
        wr_word(3, 32'h2222_0000);
`ifdef WMEM_OOB_CHECK_EN
        chk("err_oob_before", 64'(err_oob), 64'd0);
`endif
        burst(1020, 7);
`ifdef WMEM_OOB_CHECK_EN
        chk("err_oob_after", 64'(err_oob), 64'd1);
`endif

        // Zero-latency single beat on the RD_LAT=0 instance.
        chk("lat0_arready_idle", 64'(arready0), 64'd1);
        araddr  = AW'(5);
        arburst = 4'd0;
        av0     = 1'b1;
        @(posedge clk); #1;
        av0 = 1'b0;
        chk("lat0_rvalid", 64'(rvalid0), 64'd1);
        chk("lat0_rlast", 64'(rlast0), 64'd1);
        chk("lat0_rdata", 64'(rdata0), 64'h105);
        chk("lat0_arready_busy", 64'(arready0), 64'd0);
        @(posedge clk); #1;
        chk("lat0_rvalid_end", 64'(rvalid0), 64'd0);
        chk("lat0_rlast_end", 64'(rlast0), 64'd0);
        chk("lat0_arready_back", 64'(arready0), 64'd1);
        chk("lat0_rdata_hold", 64'(rdata0), 64'h105);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
